// File: rtl/gba_eeprom_pkg.sv
// Shared types and constants for the GBA EEPROM bus bridge.
// The bridge only instantiates the detect block when GBA_EEPROM_AUTODETECT_EN is defined.
package gba_eeprom_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StIssue,
    StWait,
    StResp
  } state_e;

  localparam logic [3:0]  WinRegion  = 4'hD;
  localparam logic [15:0] Win32mPage = 16'hFFFF;

  localparam logic [16:0] DetLen512A = 17'd9;
  localparam logic [16:0] DetLen512B = 17'd73;
  localparam logic [16:0] DetLen8kA  = 17'd17;
  localparam logic [16:0] DetLen8kB  = 17'd81;

  localparam int unsigned TimeoutDefault = 15;

  // Address bits [7:0] never affect the decode, so only [27:8] are passed in.
  function automatic logic in_window(logic [19:0] addr_hi, logic rom_32m);
    return (addr_hi[19:16] == WinRegion) && (!rom_32m || (addr_hi[15:0] == Win32mPage));
  endfunction

endpackage

// File: rtl/gba_eeprom_bridge_if.sv
// Cartridge-bus halfword access port of the EEPROM bridge.
// The master drives the request; the slave decodes it and returns the ack and read data.
interface gba_eeprom_bridge_if;
  logic        bus_req;
  logic        bus_we;
  logic [27:0] bus_addr;
  logic [15:0] bus_wdata;
  logic        bus_hit;
  logic        bus_ack;
  logic [15:0] bus_rdata;

  modport master (
    output bus_req, bus_we, bus_addr, bus_wdata,
    input  bus_hit, bus_ack, bus_rdata
  );

  modport slave (
    input  bus_req, bus_we, bus_addr, bus_wdata,
    output bus_hit, bus_ack, bus_rdata
  );
endinterface

// File: rtl/gba_eeprom_detect.sv
// Captures the DMA3 length of the first EEPROM access after a DMA3 start and
// derives a sticky EEPROM model from it (9/73 -> 512 B, 17/81 -> 8 KB).
module gba_eeprom_detect
  import gba_eeprom_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        accept_i,
  input  logic        dma3_start_i,
  input  logic [16:0] dma3_count_i,
  output logic [16:0] dmacount_o,
  output logic        detected_o,
  output logic        model_o
);

  logic        armed_q, armed_d;
  logic [16:0] cnt_q, cnt_d;
  logic [16:0] dmacount_q, dmacount_d;
  logic        detected_q, detected_d;
  logic        model_q, model_d;
  logic        armed_eff;
  logic [16:0] cnt_eff;

  always_comb begin
    armed_d    = armed_q;
    cnt_d      = cnt_q;
    dmacount_d = dmacount_q;
    detected_d = detected_q;
    model_d    = model_q;
    // A start coinciding with an accept hands its count straight to that access.
    armed_eff  = armed_q | dma3_start_i;
    cnt_eff    = dma3_start_i ? dma3_count_i : cnt_q;
    if (dma3_start_i) begin
      armed_d = 1'b1;
      cnt_d   = dma3_count_i;
    end
    if (accept_i && armed_eff) begin
      armed_d    = 1'b0;
      dmacount_d = cnt_eff;
      if (!detected_q) begin
        if (cnt_eff == DetLen512A || cnt_eff == DetLen512B) begin
          detected_d = 1'b1;
          model_d    = 1'b0;
        end else if (cnt_eff == DetLen8kA || cnt_eff == DetLen8kB) begin
          detected_d = 1'b1;
          model_d    = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      armed_q    <= 1'b0;
      cnt_q      <= '0;
      dmacount_q <= '0;
      detected_q <= 1'b0;
      model_q    <= 1'b0;
    end else begin
      armed_q    <= armed_d;
      cnt_q      <= cnt_d;
      dmacount_q <= dmacount_d;
      detected_q <= detected_d;
      model_q    <= model_d;
    end
  end

  assign dmacount_o = dmacount_q;
  assign detected_o = detected_q;
  assign model_o    = model_q;

endmodule

// File: rtl/gba_eeprom_bridge.sv
// Converts EEPROM-window cartridge-bus accesses into single-bit serial strobes.
// GBA_EEPROM_AUTODETECT_EN adds DMA3-length capture and automatic model detection.
module gba_eeprom_bridge
  import gba_eeprom_pkg::*;
#(
  parameter int unsigned TIMEOUT = TimeoutDefault
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                has_eeprom,
  input  logic                rom_32m,
  input  logic                cfg_model,
  gba_eeprom_bridge_if.slave  bus,
  input  logic                dma3_start,
  input  logic [16:0]         dma3_count,
  output logic                ee_cs,
  output logic                ee_valid,
  output logic                ee_write,
  output logic                ee_din,
  input  logic                ee_ready,
  input  logic                ee_dout,
  output logic                ee_model,
  output logic [16:0]         ee_dmacount,
  output logic                ee_err
);

  localparam int unsigned TmoW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [TmoW-1:0] TmoLast = TmoW'(TIMEOUT - 1);

  state_e          state_q, state_d;
  logic            we_q, we_d;
  logic            wbit_q, wbit_d;
  logic            rbit_q, rbit_d;
  logic [TmoW-1:0] tmo_q, tmo_d;
  logic            err_q, err_d;
  logic            strobe;
  logic            accept;
  logic            unused_bus;

  assign bus.bus_hit = has_eeprom & bus.bus_req & in_window(bus.bus_addr[27:8], rom_32m);
  assign accept      = (state_q == StIdle) & bus.bus_hit;
  assign unused_bus  = ^{bus.bus_wdata[15:1], bus.bus_addr[7:0]};

  always_comb begin
    state_d = state_q;
    we_d    = we_q;
    wbit_d  = wbit_q;
    rbit_d  = rbit_q;
    tmo_d   = tmo_q;
    err_d   = err_q;
    unique case (state_q)
      StIdle: begin
        if (bus.bus_hit) begin
          we_d    = bus.bus_we;
          wbit_d  = bus.bus_wdata[0];
          state_d = StIssue;
        end
      end
      StIssue: begin
        if (ee_ready) begin
          rbit_d  = ee_dout;
          state_d = StResp;
        end else begin
          tmo_d   = '0;
          state_d = StWait;
        end
      end
      StWait: begin
        if (ee_ready) begin
          rbit_d  = ee_dout;
          state_d = StResp;
        end else if (tmo_q == TmoLast) begin
          // Forced completion so a dead EEPROM cannot stall the bus.
          rbit_d  = 1'b1;
          err_d   = 1'b1;
          state_d = StResp;
        end else begin
          tmo_d = tmo_q + TmoW'(1);
        end
      end
      StResp:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      we_q    <= 1'b0;
      wbit_q  <= 1'b0;
      rbit_q  <= 1'b0;
      tmo_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      we_q    <= we_d;
      wbit_q  <= wbit_d;
      rbit_q  <= rbit_d;
      tmo_q   <= tmo_d;
      err_q   <= err_d;
    end
  end

  assign strobe        = (state_q == StIssue) || (state_q == StWait);
  assign ee_cs         = has_eeprom;
  assign ee_valid      = strobe;
  assign ee_write      = strobe & we_q;
  assign ee_din        = strobe & wbit_q;
  assign ee_err        = err_q;
  assign bus.bus_ack   = (state_q == StResp);
  assign bus.bus_rdata = {15'b0, bus.bus_ack & ~we_q & rbit_q};

`ifdef GBA_EEPROM_AUTODETECT_EN
  logic det_detected;
  logic det_model;

  gba_eeprom_detect u_detect (
    .clk          (clk),
    .rst          (rst),
    .accept_i     (accept),
    .dma3_start_i (dma3_start),
    .dma3_count_i (dma3_count),
    .dmacount_o   (ee_dmacount),
    .detected_o   (det_detected),
    .model_o      (det_model)
  );

  assign ee_model = det_detected ? det_model : cfg_model;
`else
  logic unused_dma;
  assign unused_dma  = ^{dma3_start, dma3_count, accept};
  assign ee_model    = cfg_model;
  assign ee_dmacount = '0;
`endif

endmodule

// File: tb/tb_gba_eeprom_bridge.sv
// Bench for gba_eeprom_bridge: directed scenarios plus randomized accesses, all outputs
// compared every cycle against a cycle-count-based transaction model.
module tb_gba_eeprom_bridge;

  localparam int TIMEOUT = 15;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        has_eeprom = 1'b1;
  logic        rom_32m = 1'b0;
  logic        cfg_model = 1'b0;
  logic        dma3_start = 1'b0;
  logic [16:0] dma3_count = '0;
  logic        ee_ready;
  logic        ee_dout;
  logic        ee_cs, ee_valid, ee_write, ee_din, ee_model, ee_err;
  logic [16:0] ee_dmacount;

  gba_eeprom_bridge_if bus_if ();

  gba_eeprom_bridge #(.TIMEOUT(TIMEOUT)) dut (
    .clk         (clk),
    .rst         (rst),
    .has_eeprom  (has_eeprom),
    .rom_32m     (rom_32m),
    .cfg_model   (cfg_model),
    .bus         (bus_if),
    .dma3_start  (dma3_start),
    .dma3_count  (dma3_count),
    .ee_cs       (ee_cs),
    .ee_valid    (ee_valid),
    .ee_write    (ee_write),
    .ee_din      (ee_din),
    .ee_ready    (ee_ready),
    .ee_dout     (ee_dout),
    .ee_model    (ee_model),
    .ee_dmacount (ee_dmacount),
    .ee_err      (ee_err)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;
  bit started = 0;
  int rdy_mode = 0;   // 0: always ready, 1: never ready, 2: random
  int dout_mode = 2;  // 0/1: fixed, 2: random

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit hit_of(bit has, bit req, bit rom, logic [27:0] a);
    int unsigned ua;
    ua = 32'(a);
    return has && req && ((ua >> 24) == 32'hD) && (!rom || (((ua >> 8) & 32'hFFFF) == 32'hFFFF));
  endfunction

  // ---------------- reference model ----------------
  bit          m_busy, m_ack, m_we, m_bit, m_rbit, m_err, m_armed, m_det, m_dmodel;
  int          m_k;
  logic [16:0] m_cnt, m_dmacount;
  bit          e_hit, e_strobe, eff_armed;
  logic [16:0] eff_cnt;

  initial begin
    {m_busy, m_ack, m_we, m_bit, m_rbit, m_err, m_armed, m_det, m_dmodel} = '0;
    m_k = 0; m_cnt = '0; m_dmacount = '0;
    forever begin
      @(negedge clk);
      e_hit    = hit_of(has_eeprom, bus_if.bus_req, rom_32m, bus_if.bus_addr);
      e_strobe = m_busy && !m_ack;
      if (started) begin
        chk("bus_hit", 32'(bus_if.bus_hit), 32'(e_hit));
        chk("bus_ack", 32'(bus_if.bus_ack), 32'(m_ack));
        chk("bus_rdata", 32'(bus_if.bus_rdata), 32'(m_ack && !m_we && m_rbit));
        chk("ee_cs", 32'(ee_cs), 32'(has_eeprom));
        chk("ee_valid", 32'(ee_valid), 32'(e_strobe));
        chk("ee_write", 32'(ee_write), 32'(e_strobe && m_we));
        chk("ee_din", 32'(ee_din), 32'(e_strobe && m_bit));
        chk("ee_err", 32'(ee_err), 32'(m_err));
        chk("ee_dmacount", 32'(ee_dmacount), 32'(m_dmacount));
        chk("ee_model", 32'(ee_model), 32'(m_det ? m_dmodel : cfg_model));
      end
      if (rst) begin
        {m_busy, m_ack, m_err, m_armed, m_det, m_dmodel} = '0;
        m_cnt = '0; m_dmacount = '0;
      end else begin
`ifdef GBA_EEPROM_AUTODETECT_EN
        eff_armed = m_armed || dma3_start;
        eff_cnt   = dma3_start ? dma3_count : m_cnt;
        if (dma3_start) begin m_armed = 1; m_cnt = dma3_count; end
        if (!m_busy && e_hit && eff_armed) begin
          m_armed = 0;
          m_dmacount = eff_cnt;
          if (!m_det) begin
            if (eff_cnt == 9 || eff_cnt == 73) begin m_det = 1; m_dmodel = 0; end
            else if (eff_cnt == 17 || eff_cnt == 81) begin m_det = 1; m_dmodel = 1; end
          end
        end
`endif
        // m_k counts strobe cycles since acceptance; strobe ends on ready or after TIMEOUT+1.
        if (m_ack) begin
          m_ack = 0; m_busy = 0;
        end else if (m_busy) begin
          if (ee_ready) begin m_rbit = ee_dout; m_ack = 1; end
          else if (m_k >= TIMEOUT + 1) begin m_rbit = 1; m_err = 1; m_ack = 1; end
          else m_k++;
        end else if (e_hit) begin
          m_busy = 1; m_k = 1; m_we = bus_if.bus_we; m_bit = bus_if.bus_wdata[0];
        end
      end
    end
  end

  // ---------------- EEPROM responder ----------------
  initial begin
    ee_ready = 1'b1;
    ee_dout  = 1'b0;
    forever begin
      @(posedge clk); #1;
      case (rdy_mode)
        0:       ee_ready = 1'b1;
        1:       ee_ready = 1'b0;
        default: ee_ready = ($urandom_range(0, 2) != 0);
      endcase
      ee_dout = (dout_mode == 2) ? 1'($urandom) : 1'(dout_mode);
    end
  end

  // ---------------- stimulus ----------------
  task automatic step();
    @(posedge clk); #1;
    dma3_start = 1'b0;
  endtask

  task automatic access(input logic we, input logic [27:0] addr, input logic [15:0] wd,
                        output int lat, output logic [15:0] rd);
    bus_if.bus_req = 1'b1; bus_if.bus_we = we; bus_if.bus_addr = addr; bus_if.bus_wdata = wd;
    lat = 0; rd = '0;
    if (!hit_of(has_eeprom, 1'b1, rom_32m, addr)) begin
      repeat (3) step();
      bus_if.bus_req = 1'b0;
      lat = -1;
      return;
    end
    forever begin
      @(negedge clk);
      if (bus_if.bus_ack) begin rd = bus_if.bus_rdata; break; end
      lat++;
      if (lat > 40) begin
        vectors++; miscompares++;
        $display("FAIL ack_wait: got no ack expected ack within 40 cycles at %0t", $time);
        break;
      end
      step();
    end
    step();
    bus_if.bus_req = 1'b0;
  endtask

  function automatic logic [16:0] pick_count();
    case ($urandom_range(0, 4))
      0: return 17'd9;
      1: return 17'd17;
      2: return 17'd73;
      3: return 17'd81;
      default: return 17'($urandom);
    endcase
  endfunction

  int          lat;
  logic [15:0] rd;
  logic [27:0] ra;
  int          r;

  initial begin
    bus_if.bus_req = 1'b0; bus_if.bus_we = 1'b0; bus_if.bus_addr = '0; bus_if.bus_wdata = '0;
    repeat (2) step();
    rst = 1'b0;
    started = 1;
    @(negedge clk);
    chk("rst_ack", 32'(bus_if.bus_ack), 0);
    chk("rst_rdata", 32'(bus_if.bus_rdata), 0);
    chk("rst_valid", 32'(ee_valid), 0);
    chk("rst_err", 32'(ee_err), 0);
    chk("rst_dmacount", 32'(ee_dmacount), 0);
    chk("rst_model", 32'(ee_model), 0);
    step();

    // Plain read, ready tied high, dout=1.
    rdy_mode = 0; dout_mode = 1;
    step();
    bus_if.bus_req = 1'b1; bus_if.bus_we = 1'b0; bus_if.bus_addr = 28'h0D00000;
    bus_if.bus_addr = 28'hD000000;
    @(negedge clk); chk("t1_hit", 32'(bus_if.bus_hit), 1);
    step();
    @(negedge clk); chk("t1_valid", 32'(ee_valid), 1); chk("t1_write", 32'(ee_write), 0);
    step();
    @(negedge clk); chk("t1_ack", 32'(bus_if.bus_ack), 1);
    chk("t1_rdata", 32'(bus_if.bus_rdata), 32'h0001); chk("t1_valid_off", 32'(ee_valid), 0);
    step();
    bus_if.bus_req = 1'b0;
    step();

    // 32M window: low address misses, top page write hits.
    rom_32m = 1'b1; dout_mode = 2;
    access(1'b0, 28'hD000000, 16'h0000, lat, rd);
    chk("t2_miss", 32'(lat), 32'hFFFF_FFFF);
    access(1'b1, 28'hDFFFF00, 16'hFFFF, lat, rd);
    chk("t2_lat", 32'(lat), 2);
    chk("t2_rdata", 32'(rd), 0);

    // Timeout with ee_ready held low.
    rom_32m = 1'b0; rdy_mode = 1;
    step();
    access(1'b0, 28'hD000040, 16'h0000, lat, rd);
    chk("t3_lat", 32'(lat), 17);
    chk("t3_rdata", 32'(rd), 1);
    @(negedge clk); chk("t3_err", 32'(ee_err), 1);
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    @(negedge clk); chk("t3_err_clr", 32'(ee_err), 0);
    step();

    // Reset while waiting for ee_ready.
    bus_if.bus_req = 1'b1; bus_if.bus_we = 1'b0; bus_if.bus_addr = 28'hD000010;
    repeat (5) step();
    rst = 1'b1; bus_if.bus_req = 1'b0;
    step();
    rst = 1'b0;
    @(negedge clk); chk("t6_valid", 32'(ee_valid), 0); chk("t6_ack", 32'(bus_if.bus_ack), 0);
    rdy_mode = 0;
    step(); step();
    access(1'b0, 28'hD000010, 16'h0000, lat, rd);
    chk("t6_lat", 32'(lat), 2);

    // DMA length capture and model detection.
    cfg_model = 1'b0; dma3_count = 17'd17; dma3_start = 1'b1;
    step();
    for (int i = 0; i < 17; i++) begin
      access(1'b1, 28'hD000000 + 28'(2 * i), 16'($urandom), lat, rd);
      if (i == 0) begin
        @(negedge clk);
`ifdef GBA_EEPROM_AUTODETECT_EN
        chk("t4_dmacount", 32'(ee_dmacount), 17); chk("t4_model", 32'(ee_model), 1);
`else
        chk("t5_dmacount", 32'(ee_dmacount), 0); chk("t5_model", 32'(ee_model), 0);
`endif
        step();
      end
    end
    cfg_model = 1'b1;
    @(negedge clk); chk("t4_model_cfg1", 32'(ee_model), 1);
    step();
    cfg_model = 1'b0; dma3_count = 17'd9; dma3_start = 1'b1;
    step();
    access(1'b1, 28'hD000100, 16'h0001, lat, rd);
    @(negedge clk);
`ifdef GBA_EEPROM_AUTODETECT_EN
    chk("t4_dmacount9", 32'(ee_dmacount), 9); chk("t4_model_sticky", 32'(ee_model), 1);
`else
    chk("t5_dmacount9", 32'(ee_dmacount), 0); chk("t5_model_cfg0", 32'(ee_model), 0);
`endif
    step();

    // Randomized traffic.
    rdy_mode = 2; dout_mode = 2;
    for (int n = 0; n < 300; n++) begin
      r = $urandom_range(0, 99);
      if (r < 3) begin
        rst = 1'b1; step(); rst = 1'b0;
      end else if (r < 8) begin
        has_eeprom = ($urandom_range(0, 5) != 0);
        rom_32m = 1'($urandom);
        cfg_model = 1'($urandom);
        step();
      end else if (r < 14) begin
        dma3_start = 1'b1; dma3_count = pick_count();
        step();
      end else begin
        if ($urandom_range(0, 9) == 0) begin dma3_start = 1'b1; dma3_count = pick_count(); end
        rdy_mode = ($urandom_range(0, 19) == 0) ? 1 : 2;
        case ($urandom_range(0, 3))
          0:       ra = 28'hD000000 | 28'($urandom_range(0, 32'hFFFFFF));
          1:       ra = 28'hDFFFF00 | 28'($urandom_range(0, 255));
          2:       ra = 28'($urandom);
          default: ra = 28'hDFFFF00 - 28'($urandom_range(1, 255));
        endcase
        access(1'($urandom), ra, 16'($urandom), lat, rd);
      end
    end
    rdy_mode = 0;
    repeat (3) step();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
